// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: default widths and FSM state type shared by the frame accumulator.
package sum_accumulator_pkg;
    localparam int WIDTH       = 32;
    localparam int ACC_WIDTH   = 40;
    localparam int COUNT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;
endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: reduces frames of unsigned sums into a wide total with sticky carry-out flag.
module sum_accumulator #(
    parameter int WIDTH       = sum_accumulator_pkg::WIDTH,
    parameter int ACC_WIDTH   = sum_accumulator_pkg::ACC_WIDTH,
    parameter int COUNT_WIDTH = sum_accumulator_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_sum,
    input  logic [COUNT_WIDTH-1:0] frame_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);
    import sum_accumulator_pkg::*;
    localparam int AW1 = ACC_WIDTH + 1;
    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q;
    logic [ACC_WIDTH-1:0]   out_acc_q;
    logic [COUNT_WIDTH-1:0] out_count_q;
    logic                   out_overflow_q;
    logic                   in_xfer;
    logic [COUNT_WIDTH-1:0] len_new, cnt_inc;
    logic [AW1-1:0]         sum_w;

    // HOLD is the only state where the output handshake gates acceptance
    assign in_ready = !reset && (state_q != HOLD || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign len_new  = (frame_len == '0) ? COUNT_WIDTH'(1) : frame_len;
    assign cnt_inc  = cnt_q + COUNT_WIDTH'(1);
    assign sum_w    = AW1'(acc_q) + AW1'(in_sum);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (in_xfer && state_q != ACCUM) begin
            len_d   = len_new;
            acc_d   = ACC_WIDTH'(in_sum);
            cnt_d   = COUNT_WIDTH'(1);
            ovf_d   = 1'b0;
            state_d = (len_new == COUNT_WIDTH'(1)) ? HOLD : ACCUM;
        end else if (in_xfer) begin
            acc_d   = sum_w[ACC_WIDTH-1:0];
            ovf_d   = ovf_q | sum_w[ACC_WIDTH];
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? HOLD : ACCUM;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            len_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_acc_q      <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= state_d == HOLD;
            out_acc_q      <= (state_d == HOLD) ? acc_d : '0;
            out_count_q    <= (state_d == HOLD) ? cnt_d : '0;
            out_overflow_q <= (state_d == HOLD) && ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_acc      = out_acc_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed checks of framing, back-pressure, gaps, overflow and reset.
module tb_sum_accumulator;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_overflow;
    logic [31:0] in_sum;
    logic [7:0]  frame_len, out_count;
    logic [39:0] out_acc;
    logic        in_valid2, in_ready2, out_valid2, out_overflow2;
    logic [31:0] in_sum2;
    logic [7:0]  frame_len2, out_count2;
    logic [32:0] out_acc2;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .frame_len(frame_len), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    sum_accumulator #(.WIDTH(32), .ACC_WIDTH(33), .COUNT_WIDTH(8)) dut33 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_sum(in_sum2),
        .frame_len(frame_len2), .out_valid(out_valid2), .out_ready(1'b1), .out_acc(out_acc2),
        .out_count(out_count2), .out_overflow(out_overflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
        step();
        step();
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_acc, out_count, out_overflow} !== '0) begin
            fails++; $display("FAIL reset_outputs got v=%b acc=%h cnt=%0d ovf=%b exp all 0", out_valid, out_acc, out_count, out_overflow);
        end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_frame3();
        logic [31:0] v [3] = '{32'd1, 32'd2, 32'd3};
        frame_len = 8'd3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_sum = v[i];
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL frame3_early_valid idx=%0d got=%b exp=0", i, out_valid); end
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_acc !== 40'd6 || out_count !== 8'd3 || out_overflow !== 1'b0) begin
            fails++; $display("FAIL frame3_result got v=%b acc=%0d cnt=%0d ovf=%b exp v=1 acc=6 cnt=3 ovf=0", out_valid, out_acc, out_count, out_overflow);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_acc !== 40'd0 || out_count !== 8'd0) begin
            fails++; $display("FAIL frame3_drain got v=%b acc=%0d cnt=%0d exp v=0 acc=0 cnt=0", out_valid, out_acc, out_count);
        end
    endtask

    task automatic test_len_zero();
        frame_len = 8'd0;
        in_valid = 1'b1;
        in_sum = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_acc !== 40'h00FFFFFFFF || out_count !== 8'd1 || out_overflow !== 1'b0) begin
            fails++; $display("FAIL len_zero got v=%b acc=%h cnt=%0d ovf=%b exp v=1 acc=00ffffffff cnt=1 ovf=0", out_valid, out_acc, out_count, out_overflow);
        end
        step();
    endtask

    task automatic test_overflow33();
        frame_len2 = 8'd3;
        in_sum2 = 32'hFFFF_FFFF;
        in_valid2 = 1'b1;
        step();
        step();
        tests++;
        if (out_valid2 !== 1'b0) begin fails++; $display("FAIL ovf33_early_valid got=%b exp=0", out_valid2); end
        step();
        in_valid2 = 1'b0;
        tests++;
        if (out_valid2 !== 1'b1 || out_acc2 !== 33'h0FFFFFFFD || out_count2 !== 8'd3 || out_overflow2 !== 1'b1) begin
            fails++; $display("FAIL ovf33_result got v=%b acc=%h cnt=%0d ovf=%b exp v=1 acc=0fffffffd cnt=3 ovf=1", out_valid2, out_acc2, out_count2, out_overflow2);
        end
        step();
    endtask

    task automatic test_backpressure();
        frame_len = 8'd2;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sum = 32'd10;
        step();
        in_sum = 32'd20;
        step();
        out_ready = 1'b0;
        in_sum = 32'd4;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 40'd30 || out_count !== 8'd2) begin
                fails++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b acc=%0d cnt=%0d exp rdy=0 v=1 acc=30 cnt=2", i, in_ready, out_valid, out_acc, out_count);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_consumed got v=%b exp=0", out_valid); end
        in_sum = 32'd6;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_acc !== 40'd10 || out_count !== 8'd2) begin
            fails++; $display("FAIL bp_next_frame got v=%b acc=%0d cnt=%0d exp v=1 acc=10 cnt=2", out_valid, out_acc, out_count);
        end
        step();
    endtask

    task automatic test_gaps();
        frame_len = 8'd2;
        in_valid = 1'b1;
        in_sum = 32'd5;
        step();
        in_valid = 1'b0;
        frame_len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_valid cyc=%0d got=%b exp=0", i, out_valid); end
        end
        in_valid = 1'b1;
        in_sum = 32'd7;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_acc !== 40'd12 || out_count !== 8'd2) begin
            fails++; $display("FAIL gap_result got v=%b acc=%0d cnt=%0d exp v=1 acc=12 cnt=2", out_valid, out_acc, out_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3] = '{32'd3, 32'd4, 32'd5};
        frame_len = 8'd1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sum = v[i];
            step();
            tests++;
            if (out_valid !== 1'b1 || out_acc !== {8'd0, v[i]} || out_count !== 8'd1) begin
                fails++; $display("FAIL b2b idx=%0d got v=%b acc=%0d cnt=%0d exp v=1 acc=%0d cnt=1", i, out_valid, out_acc, out_count, v[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_frame();
        frame_len = 8'd4;
        in_valid = 1'b1;
        in_sum = 32'd100;
        step();
        in_sum = 32'd200;
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_acc, out_count, out_overflow} !== '0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_outputs got v=%b acc=%0d cnt=%0d ovf=%b rdy=%b exp all 0 rdy=1", out_valid, out_acc, out_count, out_overflow, in_ready);
        end
        frame_len = 8'd2;
        in_valid = 1'b1;
        in_sum = 32'd5;
        step();
        in_sum = 32'd7;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_acc !== 40'd12 || out_count !== 8'd2 || out_overflow !== 1'b0) begin
            fails++; $display("FAIL midreset_followup got v=%b acc=%0d cnt=%0d ovf=%b exp v=1 acc=12 cnt=2 ovf=0", out_valid, out_acc, out_count, out_overflow);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_sum = '0;
        frame_len = '0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        in_sum2 = '0;
        frame_len2 = '0;
        #1;
        test_reset();
        test_frame3();
        test_len_zero();
        test_overflow33();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
